sha256_ctrl: RTL

- Sequencing controller for the SHA-256 compression datapath.
- Accepts message blocks as 16 word-serial 32-bit words over a valid/ready handshake.
- Drives schedule-load, state-init/copy, round-enable and hash-update strobes for 64 rounds per block.
- Presents a digest-valid handshake after the last block. Sits between the padding front end and the round datapath; it holds no hash state itself.

---
 rtl/sha256_ctrl_if.sv | 46 ++++
 rtl/sha256_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sha256_ctrl_if.sv
// sha256_ctrl_if: handshake and strobe bundle between the SHA-256 sequencing
// controller (slave side) and the padding front end / round datapath (master side).
interface sha256_ctrl_if #(
  parameter int DW = 32,
  parameter int RW = 6
);
  // Message block input handshake
  logic          blk_valid_i;
  logic          blk_ready_o;
  logic [DW-1:0] blk_word_i;
  logic          blk_first_i;
  logic          blk_last_i;

  // Schedule load strobes
  logic          w_load_o;
  logic [DW-1:0] w_word_o;
  logic [3:0]    word_idx_o;

  // Compression datapath strobes
  logic          state_init_o;
  logic          state_copy_o;
  logic          round_en_o;
  logic [RW-1:0] round_idx_o;
  logic          w_expand_o;
  logic [DW-1:0] k_o;
  logic          hash_update_o;

  // Digest handshake and status
  logic          digest_valid_o;
  logic          digest_ready_i;
  logic          busy_o;

  modport slave (
    input  blk_valid_i, blk_word_i, blk_first_i, blk_last_i, digest_ready_i,
    output blk_ready_o, w_load_o, w_word_o, word_idx_o, state_init_o,
           state_copy_o, round_en_o, round_idx_o, w_expand_o, k_o,
           hash_update_o, digest_valid_o, busy_o
  );

  modport master (
    output blk_valid_i, blk_word_i, blk_first_i, blk_last_i, digest_ready_i,
    input  blk_ready_o, w_load_o, w_word_o, word_idx_o, state_init_o,
           state_copy_o, round_en_o, round_idx_o, w_expand_o, k_o,
           hash_update_o, digest_valid_o, busy_o
  );
endinterface

// File: rtl/sha256_ctrl.sv
// sha256_ctrl: sequencing controller for the SHA-256 compression datapath.
// Loads 16 word-serial message words, then walks COPY -> 64 rounds -> UPDATE,
// and presents a digest handshake after the last block of a message.
// Optional feature macro: SHA256_CTRL_KROM_EN (built-in K constant ROM;
// requires ROUNDS == 64). Without it k_o is tied to zero.
module sha256_ctrl #(
  parameter int DW     = 32,
  parameter int NWORDS = 16,
  parameter int ROUNDS = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  sha256_ctrl_if.slave    bus
);

  localparam int RW = $clog2(ROUNDS);
  localparam logic [RW-1:0] LAST_WORD  = RW'(NWORDS - 1);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [RW-1:0] FIRST_EXP  = RW'(NWORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_COPY   = 3'd2,
    S_ROUND  = 3'd3,
    S_UPDATE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_cnt;        // word count in LOAD, round count in ROUND
  logic [RW-1:0] w_cnt_nxt;
  logic          r_last;       // latched last-block flag of the current block
  logic          w_last_nxt;

  logic          w_ready;
  logic          w_accept;
  logic          w_load;
  logic [3:0]    w_word_idx;
  logic          w_init;
  logic          w_round;

  // Ready only while collecting words; held low while reset is asserted.
  assign w_ready  = rst_i & ((r_state == S_IDLE) | (r_state == S_LOAD));
  assign w_accept = bus.blk_valid_i & w_ready;

  // State, counter and flag register with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state logic plus the accept-driven load strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    w_word_idx  = 4'd0;
    w_init      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Word 0: first/last are only meaningful here.
          w_load      = 1'b1;
          w_init      = bus.blk_first_i;
          w_last_nxt  = bus.blk_last_i;
          w_cnt_nxt   = RW'(1);
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_load     = 1'b1;
          w_word_idx = r_cnt[3:0];
          if (r_cnt == LAST_WORD) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_COPY;
          end else begin
            w_cnt_nxt   = r_cnt + RW'(1);
          end
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_COPY: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (r_cnt == LAST_ROUND) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_UPDATE;
        end else begin
          w_cnt_nxt   = r_cnt + RW'(1);
        end
      end
      S_UPDATE: begin
        if (r_last) begin
          w_state_nxt = S_DONE;
        end else begin
          // Mid-message block finished: ready for the next block.
          w_last_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        if (bus.digest_ready_i) begin
          w_last_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  assign w_round = (r_state == S_ROUND);

  // Load path: combinational from the accept.
  assign bus.blk_ready_o    = w_ready;
  assign bus.w_load_o       = w_load;
  assign bus.w_word_o       = bus.blk_word_i;
  assign bus.word_idx_o     = w_word_idx;
  assign bus.state_init_o   = w_init;

  // Compute strobes: pure decodes of registered state.
  assign bus.state_copy_o   = (r_state == S_COPY);
  assign bus.round_en_o     = w_round;
  assign bus.round_idx_o    = w_round ? r_cnt : '0;
  assign bus.w_expand_o     = w_round & (r_cnt >= FIRST_EXP);
  assign bus.hash_update_o  = (r_state == S_UPDATE);
  assign bus.digest_valid_o = (r_state == S_DONE);
  assign bus.busy_o         = (r_state != S_IDLE);

`ifdef SHA256_CTRL_KROM_EN
  // FIPS 180-4 round constants K[0..63].
  function automatic logic [31:0] k_lookup(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;  6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;  6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;  6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;  6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;  6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;  6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;  6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;  6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;  6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;  6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;  6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;  6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;  6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;  6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;  6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;  6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
      default: k = 32'h00000000;
    endcase
    return k;
  endfunction

  // The ROM is indexed by the round counter and only drives k_o during ROUND.
  assign bus.k_o = w_round ? DW'(k_lookup(r_cnt)) : '0;
`else
  // No ROM: the datapath supplies K itself.
  assign bus.k_o = '0;
`endif

endmodule
